// File: rtl/leds7_cmd_encoder_pkg.sv
// leds7_cmd_encoder_pkg: shared constants, encoder state enum and digit helpers for the LED byte protocol
// Contents:
//   LED_SEL_BASE   select byte for digit 0 (digit i uses LED_SEL_BASE + i)
//   LED_MAX_DIGIT  largest digit value the far-end controller displays
//   LED_NUM        digits per frame
//   enc_state_t    encoder FSM states
//   lowest_set     index of the lowest set bit of a 4-bit mask
//   valid_digits   frame_mask with out-of-range digits removed
package leds7_cmd_encoder_pkg;

    localparam logic [7:0] LED_SEL_BASE  = 8'hF0;
    localparam logic [3:0] LED_MAX_DIGIT = 4'd9;
    localparam int         LED_NUM       = 4;

    typedef enum logic [1:0] {
        IDLE,
        SEL,
        DATA,
        GAP
    } enc_state_t;

    function automatic logic [1:0] lowest_set(input logic [3:0] m);
        return m[0] ? 2'd0 : m[1] ? 2'd1 : m[2] ? 2'd2 : 2'd3;
    endfunction

    function automatic logic [3:0] valid_digits(input logic [15:0] d, input logic [3:0] m);
        logic [3:0] v;
        for (int i = 0; i < LED_NUM; i++)
            v[i] = m[i] && (d[4*i +: 4] <= LED_MAX_DIGIT);
        return v;
    endfunction

endpackage

// File: rtl/leds7_cmd_encoder.sv
// leds7_cmd_encoder: serialises a 4-digit frame into select/data byte pairs for the UART TX
// Ports:
//   clk              system clock
//   reset            synchronous active-high reset
//   frame_data[15:0] digit i in bits [4i+3:4i]
//   frame_mask[3:0]  bit i set = send digit i
//   frame_valid      frame offered, taken when frame_ready is high
//   frame_ready      encoder idle
//   uart_data[7:0]   byte to the UART TX
//   uart_data_valid  uart_data valid, held with stable data until uart_ready
//   uart_ready       UART TX takes the byte this cycle
//   busy             frame in progress
//   digit_err        one-cycle pulse: a masked digit above 9 was dropped
module leds7_cmd_encoder
    import leds7_cmd_encoder_pkg::*;
#(
    parameter int unsigned GAP_CYCLES = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] frame_data,
    input  logic [3:0]  frame_mask,
    input  logic        frame_valid,
    output logic        frame_ready,
    output logic [7:0]  uart_data,
    output logic        uart_data_valid,
    input  logic        uart_ready,
    output logic        busy,
    output logic        digit_err
);

    localparam logic [7:0] GAP_LOAD = GAP_CYCLES[7:0];
    localparam bit         HAS_GAP  = GAP_CYCLES != 0;

    enc_state_t  state, ret_state;
    logic [15:0] data_q;
    logic [3:0]  mask_q;
    logic [1:0]  idx;
    logic [7:0]  gap_cnt;
    logic [3:0]  eff_mask, rest_mask;
    logic [1:0]  next_idx;
    logic [7:0]  sel_byte, next_sel_byte, first_sel_byte, data_byte;
    logic        hs;

    always_comb begin
        eff_mask       = valid_digits(frame_data, frame_mask);
        rest_mask      = mask_q & ~(4'b1 << idx);
        next_idx       = lowest_set(rest_mask);
        sel_byte       = LED_SEL_BASE | {6'b0, idx};
        next_sel_byte  = LED_SEL_BASE | {6'b0, next_idx};
        first_sel_byte = LED_SEL_BASE | {6'b0, lowest_set(eff_mask)};
        data_byte      = {4'h0, data_q[{idx, 2'b00} +: 4]};
        hs             = uart_data_valid & uart_ready;
    end

    assign frame_ready = state == IDLE;
    assign busy        = state != IDLE;

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            ret_state       <= IDLE;
            data_q          <= 16'h0;
            mask_q          <= 4'h0;
            idx             <= 2'd0;
            gap_cnt         <= 8'd0;
            uart_data       <= 8'h00;
            uart_data_valid <= 1'b0;
            digit_err       <= 1'b0;
        end else begin
            digit_err <= 1'b0;
            case (state)
                IDLE: if (frame_valid) begin
                    data_q    <= frame_data;
                    mask_q    <= eff_mask;
                    idx       <= lowest_set(eff_mask);
                    digit_err <= (frame_mask & ~eff_mask) != 4'h0;
                    if (eff_mask == 4'h0) begin
                        // an empty frame still holds busy for one cycle (plus the gap) so digit_err lands while busy
                        state     <= GAP;
                        ret_state <= IDLE;
                        gap_cnt   <= GAP_LOAD;
                    end else begin
                        state           <= SEL;
                        uart_data       <= first_sel_byte;
                        uart_data_valid <= 1'b1;
                    end
                end
                SEL: if (hs) begin
                    if (HAS_GAP) begin
                        state           <= GAP;
                        ret_state       <= DATA;
                        gap_cnt         <= GAP_LOAD - 8'd1;
                        uart_data_valid <= 1'b0;
                    end else begin
                        state     <= DATA;
                        uart_data <= data_byte;
                    end
                end
                DATA: if (hs) begin
                    mask_q <= rest_mask;
                    idx    <= next_idx;
                    if (HAS_GAP) begin
                        state           <= GAP;
                        ret_state       <= rest_mask != 4'h0 ? SEL : IDLE;
                        gap_cnt         <= GAP_LOAD - 8'd1;
                        uart_data_valid <= 1'b0;
                    end else if (rest_mask != 4'h0) begin
                        state     <= SEL;
                        uart_data <= next_sel_byte;
                    end else begin
                        state           <= IDLE;
                        uart_data_valid <= 1'b0;
                    end
                end
                GAP: if (gap_cnt != 8'd0) begin
                    gap_cnt <= gap_cnt - 8'd1;
                end else begin
                    // idx already points at the pending digit, so the byte is rebuilt here
                    state           <= ret_state;
                    uart_data_valid <= ret_state != IDLE;
                    if (ret_state != IDLE)
                        uart_data <= ret_state == SEL ? sel_byte : data_byte;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_leds7_cmd_encoder.sv
// tb_leds7_cmd_encoder: directed and randomized checks of leds7_cmd_encoder with gap 0 and gap 3
module tb_leds7_cmd_encoder;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] frame_data;
    logic [3:0]  frame_mask;
    logic        fv0, fv1, uart_ready;
    logic        fr0, fr1, v0, v1, b0, b1, e0, e1;
    logic [7:0]  d0, d1;
    logic        sel;
    logic        o_fready, o_valid, o_busy, o_err;
    logic [7:0]  o_data;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          g;
    int          nhs;

    always #5 clk = ~clk;

    leds7_cmd_encoder #(.GAP_CYCLES(0)) dut0 (
        .clk(clk), .reset(reset), .frame_data(frame_data), .frame_mask(frame_mask),
        .frame_valid(fv0), .frame_ready(fr0), .uart_data(d0), .uart_data_valid(v0),
        .uart_ready(uart_ready), .busy(b0), .digit_err(e0)
    );

    leds7_cmd_encoder #(.GAP_CYCLES(3)) dut3 (
        .clk(clk), .reset(reset), .frame_data(frame_data), .frame_mask(frame_mask),
        .frame_valid(fv1), .frame_ready(fr1), .uart_data(d1), .uart_data_valid(v1),
        .uart_ready(uart_ready), .busy(b1), .digit_err(e1)
    );

    always_comb begin
        o_fready = sel ? fr1 : fr0;
        o_valid  = sel ? v1 : v0;
        o_busy   = sel ? b1 : b0;
        o_err    = sel ? e1 : e0;
        o_data   = sel ? d1 : d0;
        g        = sel ? 3 : 0;
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_fv(input logic v);
        if (sel) fv1 = v;
        else     fv0 = v;
    endtask

    task automatic chk_reset_values();
        chk("rst_valid", 16'(o_valid), 16'h0);
        chk("rst_data", 16'(o_data), 16'h0);
        chk("rst_busy", 16'(o_busy), 16'h0);
        chk("rst_err", 16'(o_err), 16'h0);
        chk("rst_ready", 16'(o_fready), 16'h1);
    endtask

    // Expected byte list comes straight from the protocol rules; the monitor
    // then walks it, allowing g idle cycles after every handshake.
    task automatic run_frame(input logic [15:0] d, input logic [3:0] m, input bit rnd,
                             input int stop_hs, output int hs_cnt);
        logic [7:0] q[$];
        logic [3:0] v;
        bit         err = 0;
        bit         done = 0;
        int         wait_n, nbytes;
        for (int i = 0; i < 4; i++) begin
            v = d[4*i +: 4];
            if (m[i]) begin
                if (v <= 4'd9) begin
                    q.push_back(8'(8'hF0 + i));
                    q.push_back({4'h0, v});
                end else begin
                    err = 1;
                end
            end
        end
        nbytes = q.size();
        wait_n = nbytes == 0 ? 1 + g : 0;
        hs_cnt = 0;
        @(negedge clk);
        frame_data = d;
        frame_mask = m;
        set_fv(1'b1);
        uart_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        chk("idle_ready", 16'(o_fready), 16'h1);
        for (int k = 1; k <= 400 && !done; k++) begin
            @(negedge clk);
            if (k == 1) begin
                if (rnd) begin
                    frame_data = 16'($urandom);
                    frame_mask = 4'($urandom);
                end else begin
                    set_fv(1'b0);
                end
            end
            uart_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            chk("digit_err", 16'(o_err), (k == 1) ? 16'(err) : 16'h0);
            if (wait_n > 0) begin
                chk("gap_valid", 16'(o_valid), 16'h0);
                chk("gap_busy", 16'(o_busy), 16'h1);
                wait_n--;
            end else if (q.size() == 0) begin
                chk("end_ready", 16'(o_fready), 16'h1);
                chk("end_busy", 16'(o_busy), 16'h0);
                chk("hs_count", 16'(hs_cnt), 16'(nbytes));
                done = 1;
            end else begin
                chk("valid", 16'(o_valid), 16'h1);
                chk("byte", 16'(o_data), 16'(q[0]));
                if (uart_ready) begin
                    void'(q.pop_front());
                    hs_cnt++;
                    wait_n = g;
                    if (hs_cnt == stop_hs) done = 1;
                end
            end
        end
        if (!done) begin
            n_cmp++;
            n_bad++;
            $error("FAIL timeout: frame %h mask %h got no completion, required completion", d, m);
        end
        set_fv(1'b0);
    endtask

    initial begin
        reset      = 1'b1;
        fv0        = 1'b0;
        fv1        = 1'b0;
        uart_ready = 1'b0;
        frame_data = 16'h0;
        frame_mask = 4'h0;
        sel        = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_values();
        sel = 1'b1;
        #1;
        chk_reset_values();
        sel = 1'b0;
        reset = 1'b0;
        run_frame(16'h4321, 4'hF, 0, 0, nhs);
        run_frame(16'h7050, 4'b1010, 0, 0, nhs);
        run_frame(16'h0A03, 4'hF, 0, 0, nhs);
        run_frame(16'h4321, 4'hF, 1, 0, nhs);
        chk("rand_ready_hs", 16'(nhs), 16'd8);
        run_frame(16'h1234, 4'h0, 0, 0, nhs);
        run_frame(16'hABCD, 4'hF, 0, 0, nhs);
        run_frame(16'h9999, 4'hF, 0, 0, nhs);
        repeat (20) run_frame(16'($urandom), 4'($urandom), 1, 0, nhs);
        run_frame(16'h4321, 4'hF, 0, 3, nhs);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk_reset_values();
        run_frame(16'h4321, 4'hF, 0, 0, nhs);
        sel = 1'b1;
        run_frame(16'h0009, 4'b0001, 0, 0, nhs);
        run_frame(16'h4321, 4'hF, 1, 0, nhs);
        run_frame(16'h0000, 4'h0, 0, 0, nhs);
        run_frame(16'h00B0, 4'b0010, 0, 0, nhs);
        repeat (10) run_frame(16'($urandom), 4'($urandom), 1, 0, nhs);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
